// File: rtl/core_dispatch_in_if.sv
// core_dispatch_in_if: host-side stream and per-core lanes of the dispatcher.
// slave = dispatcher view, master = host/core-array view.
interface core_dispatch_in_if #(
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 64
) ();

  logic                          s_valid;
  logic                          s_ready;
  logic                          s_last;
  logic [DATA_WIDTH-1:0]         s_data;

  logic [M_COUNT-1:0]            m_valid;
  logic [M_COUNT-1:0]            m_ready;
  logic [M_COUNT-1:0]            m_last;
  logic [M_COUNT*DATA_WIDTH-1:0] m_data;

  modport slave (
    input  s_valid,
    input  s_last,
    input  s_data,
    output s_ready,
    output m_valid,
    output m_last,
    output m_data,
    input  m_ready
  );

  modport master (
    output s_valid,
    output s_last,
    output s_data,
    input  s_ready,
    input  m_valid,
    input  m_last,
    input  m_data,
    output m_ready
  );

endinterface

// File: rtl/core_dispatch_in.sv
// core_dispatch_in: routes one packet from the host stream to one idle core.
// Ports: clk, resetb, io (s_*/m_* stream), core_idle, grant, dispatched;
// beat_count only with DISPATCH_BEAT_COUNT_EN defined.
module core_dispatch_in #(
  parameter int M_COUNT    = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic               clk,
  input  logic               resetb,
  core_dispatch_in_if.slave  io,
  input  logic [M_COUNT-1:0] core_idle,
  output logic [M_COUNT-1:0] grant,
  output logic               dispatched
`ifdef DISPATCH_BEAT_COUNT_EN
  ,
  output logic [15:0]        beat_count
`endif
);

  localparam int CORE_NUM = $clog2(M_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRAN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                  state;
  state_t                  state_d;

  // rr_ptr doubles as the grant index while a packet is owned.
  logic [CORE_NUM-1:0]     rr_ptr;
  logic [CORE_NUM-1:0]     pick_idx;
  logic [CORE_NUM-1:0]     cand;
  logic                    pick_ok;

  logic                    out_valid;
  logic                    out_last;
  logic [DATA_WIDTH-1:0]   out_data;

  logic                    tran_rdy;
  logic                    take;
  logic                    accept;
  logic                    drain;
  logic [M_COUNT-1:0]      lane_en;

  // Walk downward so the nearest idle core after rr_ptr wins.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = M_COUNT; k >= 1; k--) begin
      cand = CORE_NUM'((int'(rr_ptr) + k) % M_COUNT);
      if (core_idle[cand]) begin
        pick_ok  = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign tran_rdy = ~out_valid | io.m_ready[rr_ptr];
  assign take     = (state == ST_IDLE) & io.s_valid & pick_ok;
  assign accept   = (state == ST_TRAN) & io.s_valid & tran_rdy;
  assign drain    = (state == ST_DRAIN) & out_valid
                  & io.m_ready[rr_ptr];

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    io.s_ready = 1'b0;
    dispatched = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (take) begin
          state_d = ST_TRAN;
        end
      end
      ST_TRAN: begin
        io.s_ready = tran_rdy;
        if (accept && io.s_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        dispatched = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      grant     <= '0;
      rr_ptr    <= CORE_NUM'(M_COUNT - 1);
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (take) begin
            grant  <= M_COUNT'(1) << pick_idx;
            rr_ptr <= pick_idx;
          end
        end
        ST_TRAN: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_last  <= io.s_last;
            out_data  <= io.s_data;
          end else if (io.m_ready[rr_ptr]) begin
            out_valid <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (drain) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
          end
        end
        ST_DONE: begin
          grant <= '0;
        end
        default: begin
          grant <= '0;
        end
      endcase
    end
  end

  // Only the granted lane ever sees the slice; the rest read zero.
  for (genvar i = 0; i < M_COUNT; i++) begin : g_lane
    assign lane_en[i] = out_valid & grant[i];
    assign io.m_data[i*DATA_WIDTH +: DATA_WIDTH] =
      lane_en[i] ? out_data : '0;
  end

  assign io.m_valid = lane_en;
  assign io.m_last  = lane_en & {M_COUNT{out_last}};

`ifdef DISPATCH_BEAT_COUNT_EN
  logic [15:0] bc_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      bc_q <= '0;
    end else if (take) begin
      bc_q <= '0;
    end else if (accept && bc_q != 16'hFFFF) begin
      bc_q <= bc_q + 16'd1;
    end
  end

  assign beat_count = bc_q;
`endif

endmodule

// File: tb/tb_core_dispatch_in.sv
// tb_core_dispatch_in: random packets against a round-robin reference model.
// Each task drives one scenario and checks its own results.
module tb_core_dispatch_in;

  localparam int M  = 4;
  localparam int DW = 64;
  localparam int LW = $clog2(M);

  logic         clk = 1'b0;
  logic         resetb = 1'b0;
  logic [M-1:0] core_idle;
  logic [M-1:0] grant;
  logic         dispatched;
`ifdef DISPATCH_BEAT_COUNT_EN
  logic [15:0]  beat_count;
`endif

  core_dispatch_in_if #(.M_COUNT(M), .DATA_WIDTH(DW)) bus ();

  core_dispatch_in #(.M_COUNT(M), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .resetb     (resetb),
    .io         (bus),
    .core_idle  (core_idle),
    .grant      (grant),
    .dispatched (dispatched)
`ifdef DISPATCH_BEAT_COUNT_EN
    ,
    .beat_count (beat_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: index of the core that received the last packet.
  int rr_last = M - 1;

  logic [DW-1:0] pkt[$];
  logic [DW-1:0] rx_d[$];
  logic          rx_l[$];
  int            lane_err;
  int            stable_err;
  int            grant_chg;
  logic [M-1:0]  seen_grant;
  logic [M-1:0]  post_grant;
  int            disp_cnt;
  int            disp_cyc;
  int            last_cons;
  int            last_acc;
  bit            timeout;
  bit            aborted;

  function automatic int model_pick(input logic [M-1:0] idle);
    for (int k = 1; k <= M; k++) begin
      if (((idle >> ((rr_last + k) % M)) & 1) != 0) return (rr_last + k) % M;
    end
    return -1;
  endfunction

  function automatic logic [M-1:0] onehot(input int p);
    logic [M-1:0] v;
    v = '0;
    if (p >= 0) v = M'(1) << p;
    return v;
  endfunction

  function automatic int data_bad(input int n);
    int b;
    b = (rx_d.size() != n || pkt.size() != n) ? 1 : 0;
    if (b == 0) begin
      for (int i = 0; i < n; i++) if (rx_d[i] !== pkt[i]) b++;
    end
    return b;
  endfunction

  function automatic int last_bad(input int n);
    int b;
    b = (rx_l.size() != n) ? 1 : 0;
    if (b == 0) begin
      for (int i = 0; i < n; i++) if (rx_l[i] !== (i == n - 1)) b++;
    end
    return b;
  endfunction

  // Drives one packet and records what the core side sees; no checks here.
  task automatic run_packet(input int n, input logic [M-1:0] idle0,
                            input logic [M-1:0] idle1, input int rmode,
                            input int abort_at);
    int            sent;
    bit            have;
    bit            stall;
    bit            xfer;
    logic [LW-1:0] lv;
    logic [LW-1:0] li;
    logic [DW-1:0] pd;
    logic [DW-1:0] cd;
    logic          pl;
    logic          cl;
    pkt.delete();
    rx_d.delete();
    rx_l.delete();
    for (int i = 0; i < n; i++) pkt.push_back({$urandom, $urandom});
    sent = 0; stall = 0; pd = '0; pl = 1'b0;
    lane_err = 0; stable_err = 0; grant_chg = 0;
    seen_grant = '0; post_grant = '0;
    disp_cnt = 0; disp_cyc = -1; last_cons = -1; last_acc = -1;
    timeout = 1; aborted = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      case (rmode)
        0:       bus.m_ready = '1;
        1:       bus.m_ready = (c % 2 == 0) ? '1 : '0;
        default: bus.m_ready = M'($urandom);
      endcase
      core_idle = (sent > 0) ? idle1 : idle0;
      if (sent < n) begin
        bus.s_valid = 1'b1;
        bus.s_data  = pkt[sent];
        bus.s_last  = (sent == n - 1);
      end else begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
      end
      #1;
      if (grant != '0) begin
        if (seen_grant == '0) seen_grant = grant;
        else if (grant != seen_grant) grant_chg++;
      end
      if ($countones(bus.m_valid) > 1) lane_err++;
      have = 0; lv = '0; cd = '0; cl = 1'b0;
      for (int i = 0; i < M; i++) begin
        li = LW'(i);
        if (bus.m_valid[li]) begin
          have = 1; lv = li;
          cd = bus.m_data[li*DW +: DW];
          cl = bus.m_last[li];
          if (!grant[li]) lane_err++;
        end else if (bus.m_last[li] || bus.m_data[li*DW +: DW] != '0) begin
          lane_err++;
        end
      end
      if (stall && (!have || cd !== pd || cl !== pl)) stable_err++;
      xfer = have && bus.m_ready[lv];
      if (xfer) begin
        rx_d.push_back(cd);
        rx_l.push_back(cl);
        last_cons = c;
      end
      stall = have && !xfer;
      pd = cd; pl = cl;
      if (dispatched) begin
        disp_cnt++;
        disp_cyc = c;
        timeout = 0;
        @(negedge clk);
        #1;
        post_grant = grant;
        if (dispatched) disp_cnt++;
        break;
      end
      if (bus.s_valid && bus.s_ready) begin
        sent++;
        last_acc = c;
        if (abort_at > 0 && sent == abort_at) begin
          @(posedge clk);
          #2;
          resetb  = 1'b0;
          aborted = 1;
          timeout = 0;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_checks++;
    if (grant !== '0) begin
      n_fail++; $display("FAIL reset_grant: got %b want 0", grant);
    end
    n_checks++;
    if (bus.m_valid !== '0 || bus.m_last !== '0) begin
      n_fail++;
      $display("FAIL reset_m_vl: got %b/%b want 0", bus.m_valid, bus.m_last);
    end
    n_checks++;
    if (bus.m_data !== '0) begin
      n_fail++; $display("FAIL reset_m_data: got %h want 0", bus.m_data);
    end
    n_checks++;
    if (bus.s_ready !== 1'b0 || dispatched !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rdy_disp: got %b/%b want 0/0",
               bus.s_ready, dispatched);
    end
`ifdef DISPATCH_BEAT_COUNT_EN
    n_checks++;
    if (beat_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_beat_count: got %0d want 0", beat_count);
    end
`endif
  endtask

  task automatic test_basic();
    int p;
    p = model_pick('1);
    run_packet(3, '1, '1, 0, 0);
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++; $display("FAIL basic_timeout: got %b want 0", timeout);
    end
    n_checks++;
    if (seen_grant !== onehot(p) || seen_grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL basic_grant: got %b want %b", seen_grant, onehot(p));
    end
    n_checks++;
    if (data_bad(3) !== 0) begin
      n_fail++;
      $display("FAIL basic_data: got %0d beats/%0d bad want 3/0",
               rx_d.size(), data_bad(3));
    end
    n_checks++;
    if (last_bad(3) !== 0) begin
      n_fail++; $display("FAIL basic_last: got %0d bad want 0", last_bad(3));
    end
    n_checks++;
    if (disp_cnt !== 1 || disp_cyc !== last_cons + 1) begin
      n_fail++;
      $display("FAIL basic_dispatched: got cnt %0d cyc %0d want 1 cyc %0d",
               disp_cnt, disp_cyc, last_cons + 1);
    end
    n_checks++;
    if (post_grant !== '0 || lane_err !== 0) begin
      n_fail++;
      $display("FAIL basic_post: got grant %b lane_err %0d want 0/0",
               post_grant, lane_err);
    end
`ifdef DISPATCH_BEAT_COUNT_EN
    n_checks++;
    if (beat_count !== 16'd3) begin
      n_fail++; $display("FAIL basic_beat_count: got %0d want 3", beat_count);
    end
`endif
    rr_last = p;
  endtask

  task automatic test_round_robin();
    int p;
    for (int r = 0; r < 2; r++) begin
      p = model_pick('1);
      run_packet(2 + r, '1, '1, 0, 0);
      n_checks++;
      if (seen_grant !== onehot(p) || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got %b want %b", r, seen_grant, onehot(p));
      end
      n_checks++;
      if (data_bad(2 + r) !== 0) begin
        n_fail++;
        $display("FAIL rr_data%0d: got %0d bad want 0", r, data_bad(2 + r));
      end
      rr_last = p;
    end
  endtask

  task automatic test_no_idle();
    int bad;
    int p;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      core_idle   = '0;
      bus.m_ready = '1;
      bus.s_valid = 1'b1;
      bus.s_last  = 1'b0;
      bus.s_data  = {$urandom, $urandom};
      #1;
      if (bus.s_ready || bus.m_valid != '0 || grant != '0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL no_idle_wait: got %0d bad cycles want 0", bad);
    end
    p = model_pick(4'b1000);
    run_packet(2, 4'b1000, 4'b1000, 0, 0);
    n_checks++;
    if (seen_grant !== onehot(p) || seen_grant !== 4'b1000) begin
      n_fail++;
      $display("FAIL no_idle_grant: got %b want %b", seen_grant, onehot(p));
    end
    n_checks++;
    if (data_bad(2) !== 0 || disp_cnt !== 1) begin
      n_fail++;
      $display("FAIL no_idle_data: got bad %0d disp %0d want 0/1",
               data_bad(2), disp_cnt);
    end
    rr_last = p;
  endtask

  task automatic test_stall();
    int p;
    p = model_pick('1);
    run_packet(4, '1, '0, 1, 0);
    n_checks++;
    if (seen_grant !== onehot(p) || grant_chg !== 0) begin
      n_fail++;
      $display("FAIL stall_grant: got %b chg %0d want %b chg 0",
               seen_grant, grant_chg, onehot(p));
    end
    n_checks++;
    if (stable_err !== 0) begin
      n_fail++; $display("FAIL stall_stable: got %0d want 0", stable_err);
    end
    n_checks++;
    if (data_bad(4) !== 0 || last_bad(4) !== 0) begin
      n_fail++;
      $display("FAIL stall_data: got %0d beats bad %0d want 4/0",
               rx_d.size(), data_bad(4));
    end
    n_checks++;
    if (disp_cnt !== 1 || timeout !== 1'b0 || lane_err !== 0) begin
      n_fail++;
      $display("FAIL stall_done: got disp %0d to %b lane %0d want 1/0/0",
               disp_cnt, timeout, lane_err);
    end
    rr_last = p;
  endtask

  task automatic test_single_beat();
    int p;
    p = model_pick('1);
    run_packet(1, '1, '1, 0, 0);
    n_checks++;
    if (seen_grant !== onehot(p)) begin
      n_fail++;
      $display("FAIL single_grant: got %b want %b", seen_grant, onehot(p));
    end
    n_checks++;
    if (data_bad(1) !== 0 || last_bad(1) !== 0) begin
      n_fail++;
      $display("FAIL single_beat: got %0d beats want 1 with last",
               rx_d.size());
    end
    n_checks++;
    if (disp_cnt !== 1 || disp_cyc - last_acc !== 2) begin
      n_fail++;
      $display("FAIL single_disp: got cnt %0d delay %0d want 1/2",
               disp_cnt, disp_cyc - last_acc);
    end
    rr_last = p;
  endtask

  task automatic test_reset_mid();
    int bad;
    int p;
    run_packet(5, '1, '1, 1, 2);
    #1;
    n_checks++;
    if (aborted !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_reach: got %b want 1", aborted);
    end
    n_checks++;
    if (grant !== '0 || bus.m_valid !== '0 || bus.m_last !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: got %b/%b/%b want 0",
               grant, bus.m_valid, bus.m_last);
    end
    n_checks++;
    if (bus.m_data !== '0 || bus.s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_data: got %h/%b want 0", bus.m_data, bus.s_ready);
    end
`ifdef DISPATCH_BEAT_COUNT_EN
    n_checks++;
    if (beat_count !== 16'd0) begin
      n_fail++; $display("FAIL rstmid_beat_count: got %0d want 0", beat_count);
    end
`endif
    bus.s_valid = 1'b0;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 2) resetb = 1'b1;
      #1;
      if (dispatched !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL rstmid_no_disp: got %0d pulses want 0", bad);
    end
    rr_last = M - 1;
    p = model_pick('1);
    run_packet(5, '1, '1, 0, 0);
    n_checks++;
    if (seen_grant !== onehot(p) || seen_grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL rstmid_regrant: got %b want %b", seen_grant, onehot(p));
    end
    n_checks++;
    if (data_bad(5) !== 0 || disp_cnt !== 1) begin
      n_fail++;
      $display("FAIL rstmid_data2: got bad %0d disp %0d want 0/1",
               data_bad(5), disp_cnt);
    end
`ifdef DISPATCH_BEAT_COUNT_EN
    n_checks++;
    if (beat_count !== 16'd5) begin
      n_fail++; $display("FAIL rstmid_count5: got %0d want 5", beat_count);
    end
`endif
    rr_last = p;
  endtask

  task automatic test_random();
    int           n;
    int           p;
    logic [M-1:0] i0;
    logic [M-1:0] i1;
    for (int r = 0; r < 25; r++) begin
      n  = $urandom_range(1, 6);
      i0 = M'($urandom_range(1, (1 << M) - 1));
      i1 = M'($urandom);
      p  = model_pick(i0);
      run_packet(n, i0, i1, 2, 0);
      n_checks++;
      if (seen_grant !== onehot(p) || grant_chg !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_grant: got %b want %b (idle %b)",
                 r, seen_grant, onehot(p), i0);
      end
      n_checks++;
      if (data_bad(n) !== 0 || last_bad(n) !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_data: got %0d beats want %0d", r,
                 rx_d.size(), n);
      end
      n_checks++;
      if (disp_cnt !== 1 || disp_cyc !== last_cons + 1 || post_grant !== '0) begin
        n_fail++;
        $display("FAIL rand%0d_disp: got cnt %0d cyc %0d want 1 cyc %0d",
                 r, disp_cnt, disp_cyc, last_cons + 1);
      end
      n_checks++;
      if (stable_err !== 0 || lane_err !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_lanes: got stable %0d lane %0d want 0/0",
                 r, stable_err, lane_err);
      end
`ifdef DISPATCH_BEAT_COUNT_EN
      n_checks++;
      if (beat_count !== 16'(n)) begin
        n_fail++;
        $display("FAIL rand%0d_count: got %0d want %0d", r, beat_count, n);
      end
`endif
      rr_last = p;
    end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = '0;
    core_idle   = '0;
    resetb      = 1'b0;
    repeat (3) @(negedge clk);
    resetb = 1'b1;
    test_reset();
    test_basic();
    test_round_robin();
    test_no_idle();
    test_stall();
    test_single_beat();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
